ram_bus_arbiter: RTL and testbench
==================================

# ram_bus_arbiter

Sequences the single-port 256×32 program/data RAM of the RISC-V computer between three requesters: a boot-time program loader, the core's instruction-fetch port and the core's data port. After reset it stays in LOAD and streams loader words into RAM from address 0 while holding the core stopped. On the loader's last word it releases the core and switches to round-robin arbitration of fetch and data accesses. It drives the RAM's AS_L/WE_L/address/data_out bus directly.

## Interface
- ADDR_W, 10, byte-address width of the RAM bus.
- DATA_W, 32, word width.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  marks the final loader word.
- ld_ready  out  1  loader word accepted when ld_valid & ld_ready.
- ld_start  in  1  request to re-enter LOAD from run mode.
- ld_err  out  1  sticky flag: loader address wrapped.
- core_run  out  1  core may execute; 0 holds the core.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle fetch completion.
- if_rdata  out  DATA_W  fetch data, valid while if_ack.
- d_req  in  1  data request.
- d_we  in  1  1 = write.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle data completion.
- d_rdata  out  DATA_W  read data, valid while d_ack.
- AS_L, WE_L  out  1 each  RAM strobes, active low.
- address  out  ADDR_W  RAM byte address.
- data_out  out  DATA_W  RAM write data.
- data_in  in  DATA_W  RAM read data; valid one cycle after the strobe cycle.

## Operation
- States: LOAD, IDLE, ISSUE, RESP.
- Reset values: state LOAD, load pointer 0, RR pointer favours fetch, AS_L=1, WE_L=1, address=0, data_out=0, if_ack=d_ack=0, core_run=0, ld_err=0. ld_ready is 0 while RESET_L=0 and 1 once in LOAD.
- LOAD:
  - ld_ready=1.
  - Each accepted beat writes the word: AS_L=0, WE_L=0, address=ptr, data_out=ld_data for the following cycle. Then ptr += 4.
  - Accepting a beat with ptr=1020 and ld_last=0 wraps ptr to 0 and sets ld_err.
  - Accepting a beat with ld_last=1 writes that word and moves to IDLE.
  - if_req and d_req are ignored.
- IDLE: core_run=1. Grant a pending request; when both are pending, grant the port not granted last. The granted port then becomes last. Next state ISSUE.
- ISSUE:
  - AS_L=0.
  - address = granted address with bits [1:0] forced to 0.
  - Fetch: WE_L=1.
  - Data: WE_L=~d_we and data_out=d_wdata.
  - Next state RESP.
- RESP:
  - The granted port's ack=1, its rdata=data_in. For writes the data value is don't-care.
  - Next edge: if the other port requests, grant it (→ISSUE). Otherwise go to IDLE. The port just acked is masked for that edge.
- Requesters hold req and address until ack. If req drops mid-access, the access still completes and ack still pulses.
- ld_start=1 in IDLE or RESP: go to LOAD at the next edge instead of granting; ptr=0, core_run=0. ld_err is kept. In ISSUE it is honoured after RESP.
- RESET_L low at any point: return immediately to reset values. An in-flight write may be lost.

## Timing
- Request sampled at edge k from IDLE: ISSUE in cycle k..k+1, RAM captures at k+1, ack during cycle k+1..k+2. Requester-visible latency is 2 edges.
- Back-to-back alternating ports: one access per 2 cycles. The same port repeating costs 3 cycles (one masked IDLE edge).
- Loader: one word per cycle sustained. Write strobe is in the cycle after acceptance. core_run rises in the cycle after the last word's strobe.
- All outputs are registered or decoded from state only; no combinational path from any req to the bus.

## Test plan
- Reset, then load 3 words 0x00000013, 0x00100093, 0x00008067 with the last flagged. Expect RAM writes at 0x000/0x004/0x008, core_run=1 on the cycle after the 3rd strobe, ld_err=0.
- Fetch only: if_req with if_addr=0x004. Expect AS_L=0/WE_L=1/address=0x004 for one cycle, then if_ack with if_rdata=0x00100093 exactly 2 edges after the request.
- Simultaneous if_req (0x008) and d_req read (0x000). Expect fetch served first, then data. Acks are 2 cycles apart; d_rdata=0x00000013.
- Data write d_addr=0x013, d_wdata=0xDEADBEEF, then read 0x010. Expect the write to address 0x010 and the read to return 0xDEADBEEF.
- Stream 257 loader words without last. Expect the 257th word to land at 0x000, ld_err=1, core_run stays 0.
- During a pending fetch, assert ld_start and then pulse RESET_L low mid-ISSUE. Expect all outputs to return to reset values immediately, state LOAD, core_run=0, no ack.

Source files
------------

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: every signal between the RAM bus arbiter and its
// surroundings except the clock and reset.
//   Loader  : ld_valid/ld_data/ld_last in, ld_ready out, ld_start in, ld_err out
//   Core    : core_run out
//   Fetch   : if_req/if_addr in, if_ack/if_rdata out
//   Data    : d_req/d_we/d_addr/d_wdata in, d_ack/d_rdata out
//   RAM     : AS_L/WE_L/address/data_out out, data_in in
// Handshakes:
//   Loader: a word moves on a rising edge where ld_valid & ld_ready are both 1.
//   Fetch/data: req and address are held by the requester until the one-cycle
//   ack; rdata is valid only while ack is 1.
// Modports: master = the arbiter (it owns the RAM bus), slave = the environment.
interface ram_bus_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_start;
  logic              ld_err;
  logic              core_run;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              AS_L;
  logic              WE_L;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport master (
    input  ld_valid, ld_data, ld_last, ld_start,
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, data_in,
    output ld_ready, ld_err, core_run, if_ack, if_rdata, d_ack, d_rdata,
    output AS_L, WE_L, address, data_out
  );

  modport slave (
    output ld_valid, ld_data, ld_last, ld_start,
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, data_in,
    input  ld_ready, ld_err, core_run, if_ack, if_rdata, d_ack, d_rdata,
    input  AS_L, WE_L, address, data_out
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares the single-port 256x32 program/data RAM between the
// boot loader, the core's fetch port and the core's data port.
// After reset the block sits in LOAD, writing one loader word per cycle from
// address 0 while the core is held. The last loader word releases the core and
// fetch/data accesses are then served round-robin, two cycles per access.
// Ports:
//   CLOCK_50   system clock, rising edge
//   RESET_L    asynchronous active-low reset
//   bus        ram_bus_arbiter_if.master (loader, fetch, data, RAM bus)
//   dbg_state  current FSM state (LOAD=0, IDLE=1, ISSUE=2, RESP=3)
// Every output except the rdata pass-throughs is a register, so no request
// input reaches the RAM bus combinationally.
module ram_bus_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_L,
  ram_bus_arbiter_if.master      bus,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Byte address of the final word; accepting a non-last beat here wraps.
  localparam logic [ADDR_W-1:0] PTR_LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              grant_data;   // port being served: 1 = data, 0 = fetch
  logic              last_data;    // port granted most recently
  logic              ld_pend;      // ld_start seen during ISSUE
  logic              start_grant;
  logic              grant_nxt;
  logic              ld_beat;

  assign dbg_state    = state;
  assign bus.if_rdata = bus.data_in;
  assign bus.d_rdata  = bus.data_in;
  assign ld_beat      = (state == LOAD) && bus.ld_valid && bus.ld_ready;

  always_comb begin
    state_nxt   = state;
    start_grant = 1'b0;
    grant_nxt   = grant_data;
    case (state)
      LOAD: begin
        if (ld_beat && bus.ld_last) state_nxt = IDLE;
      end
      IDLE: begin
        if (bus.ld_start) begin
          state_nxt = LOAD;
        end else if (bus.if_req || bus.d_req) begin
          start_grant = 1'b1;
          state_nxt   = ISSUE;
          if (bus.if_req && bus.d_req) grant_nxt = ~last_data;
          else                         grant_nxt = bus.d_req;
        end
      end
      ISSUE: begin
        state_nxt = RESP;
      end
      RESP: begin
        // The port just acked is masked; only the other one may follow.
        if (bus.ld_start || ld_pend) begin
          state_nxt = LOAD;
        end else if (grant_data ? bus.if_req : bus.d_req) begin
          start_grant = 1'b1;
          grant_nxt   = ~grant_data;
          state_nxt   = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state        <= LOAD;
      ptr          <= '0;
      grant_data   <= 1'b0;
      last_data    <= 1'b1;   // fetch wins the first tie
      ld_pend      <= 1'b0;
      bus.ld_ready <= 1'b0;
      bus.ld_err   <= 1'b0;
      bus.core_run <= 1'b0;
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.AS_L     <= 1'b1;
      bus.WE_L     <= 1'b1;
      bus.address  <= '0;
      bus.data_out <= {DATA_W{1'b0}};
    end else begin
      state        <= state_nxt;
      bus.ld_ready <= (state_nxt == LOAD);
      // Delayed by one cycle on the way out of LOAD so the core starts after
      // the last loader strobe; dropped at once on the way back in.
      bus.core_run <= (state != LOAD) && (state_nxt != LOAD);
      bus.AS_L     <= 1'b1;
      bus.WE_L     <= 1'b1;
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;

      if (ld_beat) begin
        bus.AS_L     <= 1'b0;
        bus.WE_L     <= 1'b0;
        bus.address  <= ptr;
        bus.data_out <= bus.ld_data;
        ptr          <= ptr + ADDR_W'(4);
        if (ptr == PTR_LAST && !bus.ld_last) bus.ld_err <= 1'b1;
      end

      // Requesters hold their address until ack, so sampling it at the
      // grant edge is enough for the whole access.
      if (start_grant) begin
        grant_data <= grant_nxt;
        last_data  <= grant_nxt;
        bus.AS_L   <= 1'b0;
        if (grant_nxt) begin
          bus.address  <= bus.d_addr & WORD_MASK;
          bus.WE_L     <= ~bus.d_we;
          bus.data_out <= bus.d_wdata;
        end else begin
          bus.address  <= bus.if_addr & WORD_MASK;
        end
      end

      if (state == ISSUE) begin
        bus.if_ack <= ~grant_data;
        bus.d_ack  <= grant_data;
        if (bus.ld_start) ld_pend <= 1'b1;
      end

      if (state != LOAD && state_nxt == LOAD) begin
        ptr     <= '0;
        ld_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  logic        clk;
  logic        rst_l;
  logic [1:0]  dbg_state;
  logic [31:0] mem [0:255];
  int          vectors;
  int          miscompares;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  ram_bus_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  ram_bus_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLOCK_50  (clk),
    .RESET_L   (rst_l),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: writes land at the end of the strobe cycle, read data is
  // presented for the cycle after the strobe.
  always @(posedge clk) begin
    if (!bus.AS_L) begin
      if (!bus.WE_L) mem[bus.address[9:2]] <= bus.data_out;
      else           bus.data_in <= mem[bus.address[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_as_l"},     32'(bus.AS_L),     32'd1);
    chk({pfx, "_we_l"},     32'(bus.WE_L),     32'd1);
    chk({pfx, "_address"},  32'(bus.address),  32'd0);
    chk({pfx, "_data_out"}, bus.data_out,      32'd0);
    chk({pfx, "_if_ack"},   32'(bus.if_ack),   32'd0);
    chk({pfx, "_d_ack"},    32'(bus.d_ack),    32'd0);
    chk({pfx, "_core_run"}, 32'(bus.core_run), 32'd0);
    chk({pfx, "_ld_err"},   32'(bus.ld_err),   32'd0);
    chk({pfx, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    chk({pfx, "_state"},    32'(dbg_state),    32'(S_LOAD));
  endtask

  task automatic drive_idle();
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.ld_start = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_l       = 1'b0;
    bus.data_in = '0;
    drive_idle();
    repeat (2) tick();
    chk_reset_vals("rst");

    rst_l = 1'b1;
    tick();
    chk("rst_ld_ready_up", 32'(bus.ld_ready), 32'd1);

    // Boot load of three words
    bus.ld_valid = 1'b1; bus.ld_data = 32'h0000_0013; bus.ld_last = 1'b0;
    tick();
    chk("ld0_as_l", 32'(bus.AS_L), 32'd0);
    chk("ld0_we_l", 32'(bus.WE_L), 32'd0);
    chk("ld0_addr", 32'(bus.address), 32'h000);
    chk("ld0_data", bus.data_out, 32'h0000_0013);
    bus.ld_data = 32'h0010_0093;
    tick();
    chk("ld1_addr", 32'(bus.address), 32'h004);
    bus.ld_data = 32'h0000_8067; bus.ld_last = 1'b1;
    tick();
    chk("ld2_addr", 32'(bus.address), 32'h008);
    chk("ld2_data", bus.data_out, 32'h0000_8067);
    chk("ld2_run_low", 32'(bus.core_run), 32'd0);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    tick();
    chk("ld_run_high", 32'(bus.core_run), 32'd1);
    chk("ld_as_off", 32'(bus.AS_L), 32'd1);
    chk("ld_err_clear", 32'(bus.ld_err), 32'd0);
    chk("ld_ready_off", 32'(bus.ld_ready), 32'd0);
    chk("mem0", mem[0], 32'h0000_0013);
    chk("mem1", mem[1], 32'h0010_0093);
    chk("mem2", mem[2], 32'h0000_8067);

    // Fetch only
    bus.if_req = 1'b1; bus.if_addr = 10'h004;
    tick();
    chk("if_issue_state", 32'(dbg_state), 32'(S_ISSUE));
    chk("if_as_l", 32'(bus.AS_L), 32'd0);
    chk("if_we_l", 32'(bus.WE_L), 32'd1);
    chk("if_addr", 32'(bus.address), 32'h004);
    chk("if_ack_early", 32'(bus.if_ack), 32'd0);
    tick();
    chk("if_ack", 32'(bus.if_ack), 32'd1);
    chk("if_rdata", bus.if_rdata, 32'h0010_0093);
    chk("if_as_off", 32'(bus.AS_L), 32'd1);
    bus.if_req = 1'b0;
    tick();
    chk("if_ack_pulse", 32'(bus.if_ack), 32'd0);
    chk("if_back_idle", 32'(dbg_state), 32'(S_IDLE));

    // Data write to a misaligned address, then read back
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h013; bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("dw_as_l", 32'(bus.AS_L), 32'd0);
    chk("dw_we_l", 32'(bus.WE_L), 32'd0);
    chk("dw_addr", 32'(bus.address), 32'h010);
    chk("dw_data", bus.data_out, 32'hDEAD_BEEF);
    tick();
    chk("dw_ack", 32'(bus.d_ack), 32'd1);
    chk("dw_mem", mem[4], 32'hDEAD_BEEF);
    bus.d_we = 1'b0; bus.d_addr = 10'h010;
    tick();
    chk("dr_masked_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("dr_masked_as_l", 32'(bus.AS_L), 32'd1);
    tick();
    chk("dr_as_l", 32'(bus.AS_L), 32'd0);
    chk("dr_we_l", 32'(bus.WE_L), 32'd1);
    chk("dr_addr", 32'(bus.address), 32'h010);
    tick();
    chk("dr_ack", 32'(bus.d_ack), 32'd1);
    chk("dr_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    bus.d_req = 1'b0;
    tick();

    // Simultaneous requests; data was granted last so fetch goes first
    bus.if_req = 1'b1; bus.if_addr = 10'h008;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h000;
    tick();
    chk("both_first_addr", 32'(bus.address), 32'h008);
    tick();
    chk("both_if_ack", 32'(bus.if_ack), 32'd1);
    chk("both_d_ack_low", 32'(bus.d_ack), 32'd0);
    chk("both_if_rdata", bus.if_rdata, 32'h0000_8067);
    bus.if_req = 1'b0;
    tick();
    chk("both_second_as_l", 32'(bus.AS_L), 32'd0);
    chk("both_second_addr", 32'(bus.address), 32'h000);
    chk("both_if_ack_off", 32'(bus.if_ack), 32'd0);
    tick();
    chk("both_d_ack", 32'(bus.d_ack), 32'd1);
    chk("both_d_rdata", bus.d_rdata, 32'h0000_0013);
    bus.d_req = 1'b0;
    tick();

    // Re-enter LOAD and overrun the RAM
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("rl_state", 32'(dbg_state), 32'(S_LOAD));
    chk("rl_core_run", 32'(bus.core_run), 32'd0);
    chk("rl_ld_ready", 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_last = 1'b0;
    for (int i = 0; i < 257; i++) begin
      bus.ld_data = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 254) chk("wrap_err_before", 32'(bus.ld_err), 32'd0);
      if (i == 255) chk("wrap_err_set", 32'(bus.ld_err), 32'd1);
    end
    chk("wrap_addr", 32'(bus.address), 32'h000);
    chk("wrap_data", bus.data_out, 32'hA000_0100);
    bus.ld_valid = 1'b0;
    tick();
    chk("wrap_mem0", mem[0], 32'hA000_0100);
    chk("wrap_mem255", mem[255], 32'hA000_00FF);
    chk("wrap_run_low", 32'(bus.core_run), 32'd0);
    chk("wrap_err_sticky", 32'(bus.ld_err), 32'd1);

    // Finish this load so the core runs again
    bus.ld_valid = 1'b1; bus.ld_last = 1'b1; bus.ld_data = 32'h1234_5678;
    tick();
    chk("fin_addr", 32'(bus.address), 32'h004);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    tick();
    chk("fin_run", 32'(bus.core_run), 32'd1);

    // Reset in the middle of a fetch ISSUE with ld_start raised
    bus.if_req = 1'b1; bus.if_addr = 10'h00C;
    tick();
    chk("mr_issue", 32'(dbg_state), 32'(S_ISSUE));
    bus.ld_start = 1'b1;
    #2;
    rst_l = 1'b0;
    #1;
    chk_reset_vals("mr");
    bus.ld_start = 1'b0;
    bus.if_req   = 1'b0;
    tick();
    chk("mr_hold_ack", 32'(bus.if_ack), 32'd0);
    rst_l = 1'b1;
    tick();
    chk("mr_post_ack", 32'(bus.if_ack), 32'd0);
    chk("mr_post_state", 32'(dbg_state), 32'(S_LOAD));
    chk("mr_post_ready", 32'(bus.ld_ready), 32'd1);
    chk("mr_post_run", 32'(bus.core_run), 32'd0);
    tick();
    chk("mr_post_as_l", 32'(bus.AS_L), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
